// File: rtl/ic_74595.sv
// ic_74595: clk-synchronous model of an 8-bit serial-in / parallel-out shift
// register with a storage register and tri-state outputs. SRCLK, SER, RCLK and
// SRCLR are asynchronous strobes. They are brought into the clk domain through
// equal-depth synchroniser chains. All register updates then happen on clk.

// One synchroniser chain. It is instantiated once per asynchronous input.
module ic_74595_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    // Shift the raw input through STAGES flops; everything resets to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];
endmodule

module ic_74595 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic SRCLK,
    input  logic SER,
    input  logic RCLK,
    input  logic SRCLR,
    input  logic OE_bar,
    output logic Qa,
    output logic Qb,
    output logic Qc,
    output logic Qd,
    output logic Qe,
    output logic Qf,
    output logic Qg,
    output logic Qh,
    output logic Qh_bar
);
    // Lane order of the synchroniser bank
    localparam int L_SRCLK  = 0;
    localparam int L_SER    = 1;
    localparam int L_RCLK   = 2;
    localparam int L_SRCLR  = 3;
    localparam int NUM_SYNC = 4;

    logic [NUM_SYNC-1:0] async_in;
    logic [NUM_SYNC-1:0] sync_out;

    assign async_in[L_SRCLK] = SRCLK;
    assign async_in[L_SER]   = SER;
    assign async_in[L_RCLK]  = RCLK;
    assign async_in[L_SRCLR] = SRCLR;

    // All lanes use the same depth. This keeps SER aligned with the SRCLK edge it belongs to.
    for (genvar i = 0; i < NUM_SYNC; i++) begin : g_sync
        ic_74595_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (async_in[i]),
            .q   (sync_out[i])
        );
    end

    logic srclk_s, ser_s, rclk_s, srclr_s;
    assign srclk_s = sync_out[L_SRCLK];
    assign ser_s   = sync_out[L_SER];
    assign rclk_s  = sync_out[L_RCLK];
    assign srclr_s = sync_out[L_SRCLR];

    logic srclk_hist, rclk_hist;
    logic srclk_rise, rclk_rise;

    // History flops for edge detection. Because they reset to 0, a strobe held
    // high through reset release still produces exactly one rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            srclk_hist <= 1'b0;
            rclk_hist  <= 1'b0;
        end else begin
            srclk_hist <= srclk_s;
            rclk_hist  <= rclk_s;
        end
    end

    assign srclk_rise = srclk_s & ~srclk_hist;
    assign rclk_rise  = rclk_s  & ~rclk_hist;

    logic [7:0] sr;
    logic [7:0] st;

    // Shift register. A low clear holds it at zero and masks shift edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             sr <= 8'h00;
        else if (!srclr_s)   sr <= 8'h00;
        else if (srclk_rise) sr <= {sr[6:0], ser_s};
    end

    // Storage register captures the pre-shift value. When the clear is active,
    // it captures zero, even in the first clear cycle when sr still holds old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            st <= 8'h00;
        else if (rclk_rise) st <= srclr_s ? sr : 8'h00;
    end

    // OE_bar acts directly on the output drivers, with no synchronisation
    assign Qa = OE_bar ? 1'bz : st[0];
    assign Qb = OE_bar ? 1'bz : st[1];
    assign Qc = OE_bar ? 1'bz : st[2];
    assign Qd = OE_bar ? 1'bz : st[3];
    assign Qe = OE_bar ? 1'bz : st[4];
    assign Qf = OE_bar ? 1'bz : st[5];
    assign Qg = OE_bar ? 1'bz : st[6];
    assign Qh = OE_bar ? 1'bz : st[7];

    // The cascade output is always driven from the last shift stage
    assign Qh_bar = sr[7];
endmodule

// File: tb/tb_ic_74595.sv
// Directed bench for ic_74595 with hand-computed expectations (SYNC_STAGES=2).
module tb_ic_74595;
    logic clk, rst, SRCLK, SER, RCLK, SRCLR, OE_bar;
    wire  qa, qb, qc, qd, qe, qf, qg, qh, qh_bar;
    wire  [7:0] q = {qh, qg, qf, qe, qd, qc, qb, qa};

    int n_chk  = 0;
    int n_pass = 0;

    ic_74595 #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .SRCLK(SRCLK), .SER(SER), .RCLK(RCLK),
        .SRCLR(SRCLR), .OE_bar(OE_bar),
        .Qa(qa), .Qb(qb), .Qc(qc), .Qd(qd), .Qe(qe), .Qf(qf), .Qg(qg), .Qh(qh),
        .Qh_bar(qh_bar)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One SRCLK pulse, 3 clk high / 3 clk low, SER held across it
    task automatic send(input logic b);
        SER   = b;
        SRCLK = 1'b1;
        repeat (3) @(negedge clk);
        SRCLK = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // First bit sent ends up on stage 7
    task automatic shift_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send(v[i]);
    endtask

    task automatic latch();
        RCLK = 1'b1;
        repeat (3) @(negedge clk);
        RCLK = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; SRCLK = 1'b0; SER = 1'b0; RCLK = 1'b0; SRCLR = 1'b1; OE_bar = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_q", q, 8'h00);
        chk("rst_qhb", {7'd0, qh_bar}, 8'h00);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // single one walked to Qh
        send(1'b1);
        repeat (7) send(1'b0);
        chk("walk_hold", q, 8'h00);
        chk("walk_qhb", {7'd0, qh_bar}, 8'h01);
        latch();
        chk("walk_q", q, 8'h80);

        // byte pattern; outputs hold until RCLK
        shift_byte(8'b1011_0010);
        chk("pat_hold", q, 8'h80);
        latch();
        chk("pat_q", q, 8'hB2);

        // SRCLK latency: sr updates on the 3rd clk rise after SRCLK rises
        shift_byte(8'h40);
        chk("lat_pre", {7'd0, qh_bar}, 8'h00);
        SER = 1'b0; SRCLK = 1'b1;
        @(negedge clk); chk("lat_1", {7'd0, qh_bar}, 8'h00);
        @(negedge clk); chk("lat_2", {7'd0, qh_bar}, 8'h00);
        @(negedge clk); chk("lat_3", {7'd0, qh_bar}, 8'h01);
        // held high: one shift only (a second would give 0x00)
        repeat (10) @(negedge clk);
        chk("level_qhb", {7'd0, qh_bar}, 8'h01);
        SRCLK = 1'b0;
        repeat (3) @(negedge clk);
        latch();
        chk("level_q", q, 8'h80);

        // output enable
        shift_byte(8'hFF);
        latch();
        chk("oe_on", q, 8'hFF);
        OE_bar = 1'b1;
        #1;
        chk("oe_off_not_driven", {7'd0, q === 8'hFF}, 8'h00);
        chk("oe_off_qhb", {7'd0, qh_bar}, 8'h01);
        OE_bar = 1'b0;
        #1;
        chk("oe_restore", q, 8'hFF);
        @(negedge clk);

        // clear: outputs keep A5 until RCLK; SRCLK ignored while clear is low
        shift_byte(8'hA5);
        latch();
        chk("clr_pre", q, 8'hA5);
        SRCLR = 1'b0;
        repeat (3) @(negedge clk);
        send(1'b1);
        SRCLR = 1'b1;
        repeat (4) @(negedge clk);
        chk("clr_hold", q, 8'hA5);
        chk("clr_qhb", {7'd0, qh_bar}, 8'h00);
        latch();
        chk("clr_q", q, 8'h00);

        // RCLK during active clear loads zero
        shift_byte(8'h3C);
        latch();
        chk("clr2_pre", q, 8'h3C);
        SRCLR = 1'b0;
        repeat (4) @(negedge clk);
        latch();
        chk("clr2_q", q, 8'h00);
        SRCLR = 1'b1;
        repeat (4) @(negedge clk);

        // simultaneous SRCLK and RCLK
        shift_byte(8'h01);
        SER = 1'b0; SRCLK = 1'b1; RCLK = 1'b1;
        repeat (3) @(negedge clk);
        SRCLK = 1'b0; RCLK = 1'b0;
        repeat (3) @(negedge clk);
        chk("simul_st", q, 8'h01);
        latch();
        chk("simul_sr", q, 8'h02);

        // async reset mid-shift
        shift_byte(8'hFF);
        latch();
        SER = 1'b1; SRCLK = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_q", q, 8'h00);
        chk("arst_qhb", {7'd0, qh_bar}, 8'h00);
        SRCLK = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send(1'b1);
        latch();
        chk("arst_shift", q, 8'h01);

        // SRCLK held high through reset release gives one edge
        SER = 1'b1; SRCLK = 1'b1; rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        SRCLK = 1'b0;
        repeat (3) @(negedge clk);
        latch();
        chk("held_rel", q, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ic_74595.md
IC_74595 -- requirements
Module: ic_74595

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, minimum 2: number of synchroniser flops on each asynchronous control/data input.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port SRCLK, input, 1 bit: shift clock strobe, asynchronous to clk, rising-edge significant.
REQ-005 SHALL have port SER, input, 1 bit: serial data, sampled with SRCLK.
REQ-006 SHALL have port RCLK, input, 1 bit: storage (latch) clock strobe, asynchronous to clk, rising-edge significant.
REQ-007 SHALL have port SRCLR, input, 1 bit: shift-register clear, active-low.
REQ-008 SHALL have port OE_bar, input, 1 bit: output enable, active-low.
REQ-009 SHALL have ports Qa..Qh, outputs, 1 bit each: parallel outputs, storage register bits 0..7, tri-stateable.
REQ-010 SHALL have port Qh_bar, output, 1 bit: serial cascade output, equal to shift register stage 7, never tri-stated.

Function
REQ-011 SHALL pass SRCLK, SER, RCLK and SRCLR each through an SYNC_STAGES-deep flop chain on clk; SER and SRCLK SHALL use equal depth so they stay aligned.
REQ-012 SHALL keep one extra history flop per synchronised SRCLK/RCLK and detect a rising edge as history=0, synchronised=1.
REQ-013 SHALL hold an 8-bit shift register sr[7:0] and an 8-bit storage register st[7:0].
REQ-014 On a detected SRCLK rise with synchronised SRCLR=1, SHALL update sr <= {sr[6:0], SER_sync}: Qa-stage takes SER, each stage moves one toward Qh.
REQ-015 Latency: an SRCLK rise stable for setup SHALL update sr at the (SYNC_STAGES+1)th clk rising edge after it; same for RCLK and st.
REQ-016 While synchronised SRCLR=0, SHALL hold sr at 8'h00 every cycle and ignore SRCLK edges; st SHALL be unaffected.
REQ-017 On a detected RCLK rise, SHALL load st <= sr (value before any shift in the same cycle).
REQ-018 Simultaneous SRCLK and RCLK detected rises SHALL load st with pre-shift sr and shift sr, matching a storage register one stage behind.
REQ-019 RCLK rise while SRCLR=0 SHALL load st with 8'h00 (sr as cleared).
REQ-020 Qa..Qh SHALL equal st[0]..st[7] when OE_bar=0 and be high-impedance when OE_bar=1; OE_bar SHALL act combinationally, unsynchronised.
REQ-021 Qh_bar SHALL equal sr[7] continuously, independent of OE_bar and RCLK.
REQ-022 Pulses of SRCLK/RCLK shorter than one clk period MAY be missed; each pulse high and low for >=2 clk periods SHALL be counted exactly once.
REQ-023 SRCLK held high continuously SHALL cause only one shift (edge, not level, sensitive).

Reset
REQ-024 rst=1 SHALL immediately clear sr, st, all synchroniser and history flops to 0, independent of clk.
REQ-025 During and after reset until a new RCLK rise, Qa..Qh SHALL read 0 (OE_bar=0) and Qh_bar SHALL read 0.
REQ-026 Synchroniser flops for SRCLR SHALL reset to 0, so clear is active for SYNC_STAGES cycles after rst release.
REQ-027 An SRCLK/RCLK held high through reset release SHALL register one rising edge once synchronised.

Verification
REQ-028 Reset, SRCLR=1, SER=1 for one SRCLK rise then 0 for 7 rises, one RCLK rise -> Qh=1, Qa..Qg=0, Qh_bar=1.
REQ-029 Shift 8'b1011_0010 (first bit sent lands on Qh), RCLK -> {Qh..Qa}=1011_0010; before RCLK outputs keep prior value.
REQ-030 OE_bar=1 with st=8'hFF -> Qa..Qh all Z, Qh_bar still driven; OE_bar=0 -> 8'hFF restored without new RCLK.
REQ-031 sr=8'hA5, SRCLR pulsed low then RCLK -> Qa..Qh=0, Qh_bar=0; without RCLK outputs keep 8'hA5.
REQ-032 SRCLK and RCLK rise together with sr=8'h01, SER=0 -> st=8'h01, sr=8'h02.
REQ-033 rst asserted mid-shift (between clk edges) -> sr, st, Qh_bar=0 immediately; next valid SRCLK rise shifts from 8'h00.
